pipe_stage_hs: RTL

//  Parametrised EX->MEM pipeline stage register with a valid/ready handshake,
//  a 2-entry skid buffer, flush and forwarding taps. It lets MEM back-pressure
//  EX without losing in-flight ops, and lets hazard logic kill wrong-path ops.

---
 rtl/pipe_stage_hs_if.sv | 42 ++++
 rtl/pipe_stage_hs.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/pipe_stage_hs_if.sv
// EX->MEM handshake bundle for pipe_stage_hs: input beat, output entry, flush, perf counters.
// master = EX/MEM environment side, slave = the pipeline stage.
interface pipe_stage_hs_if #(
    parameter int unsigned N     = 32,
    parameter int unsigned AW    = 4,
    parameter int unsigned CNT_W = 16
) ();
    logic             flush_i;
    logic             in_valid_i;
    logic             in_ready_o;
    logic [N-1:0]     rd2_i;
    logic [N-1:0]     alu_i;
    logic [AW-1:0]    a3_i;
    logic             rf_we_i;
    logic             mem_we_i;
    logic             wb_sel_i;
    logic             out_valid_o;
    logic             out_ready_i;
    logic [N-1:0]     rd2_o;
    logic [N-1:0]     alu_o;
    logic [AW-1:0]    a3_o;
    logic             rf_we_o;
    logic             mem_we_o;
    logic             wb_sel_o;
    logic             fwd_hit_o;
    logic [CNT_W-1:0] stall_cnt_o;
    logic [CNT_W-1:0] bubble_cnt_o;

    modport master (
        output flush_i, in_valid_i, rd2_i, alu_i, a3_i, rf_we_i, mem_we_i, wb_sel_i,
               out_ready_i,
        input  in_ready_o, out_valid_o, rd2_o, alu_o, a3_o, rf_we_o, mem_we_o,
               wb_sel_o, fwd_hit_o, stall_cnt_o, bubble_cnt_o
    );

    modport slave (
        input  flush_i, in_valid_i, rd2_i, alu_i, a3_i, rf_we_i, mem_we_i, wb_sel_i,
               out_ready_i,
        output in_ready_o, out_valid_o, rd2_o, alu_o, a3_o, rf_we_o, mem_we_o,
               wb_sel_o, fwd_hit_o, stall_cnt_o, bubble_cnt_o
    );
endinterface

// File: rtl/pipe_stage_hs.sv
// EX->MEM pipeline stage: valid/ready handshake, 2-entry skid buffer, flush, forwarding tap.
// Optional PIPE_PERF_CNT_EN builds saturating stall/bubble counters; otherwise they read 0.
module pipe_stage_hs #(
    parameter int unsigned N     = 32,
    parameter int unsigned AW    = 4,
    parameter int unsigned CNT_W = 16
) (
    input  logic CLK,
    input  logic RST,
    pipe_stage_hs_if.slave bus
);
    typedef struct packed {
        logic [N-1:0]  rd2;
        logic [N-1:0]  alu;
        logic [AW-1:0] a3;
        logic          rf_we;
        logic          mem_we;
        logic          wb_sel;
    } payload_t;

    typedef enum logic [1:0] {S_EMPTY, S_ONE, S_TWO} state_t;

    state_t   state_q, state_d;
    payload_t main_q, main_d;
    payload_t skid_q, skid_d;
    payload_t in_pl;
    logic     out_valid_q, out_valid_d;
    logic     in_ready_q, in_ready_d;
    logic     rf_we_out_q, rf_we_out_d;
    logic     mem_we_out_q, mem_we_out_d;
    logic     fwd_hit_q, fwd_hit_d;
    logic     accept, pop;

    // Next state, entry loads and registered output values.
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        in_pl   = '{rd2: bus.rd2_i, alu: bus.alu_i, a3: bus.a3_i, rf_we: bus.rf_we_i,
                    mem_we: bus.mem_we_i, wb_sel: bus.wb_sel_i};
        accept  = bus.in_valid_i & in_ready_q & ~bus.flush_i;
        pop     = out_valid_q & bus.out_ready_i;

        case (state_q)
            S_EMPTY: begin
                if (accept) begin
                    state_d = S_ONE;
                    main_d  = in_pl;
                end
            end
            S_ONE: begin
                if (accept && pop) begin
                    main_d = in_pl;
                end else if (accept) begin
                    state_d = S_TWO;
                    skid_d  = in_pl;
                end else if (pop) begin
                    state_d = S_EMPTY;
                end
            end
            S_TWO: begin
                if (pop) begin
                    state_d = S_ONE;
                    main_d  = skid_q;
                end
            end
            default: state_d = S_EMPTY;
        endcase

        // Flush kills both entries; payload regs simply hold their stale contents.
        if (bus.flush_i) begin
            state_d = S_EMPTY;
            main_d  = main_q;
            skid_d  = skid_q;
        end

        out_valid_d  = (state_d != S_EMPTY);
        in_ready_d   = (state_d != S_TWO);
        rf_we_out_d  = out_valid_d & main_d.rf_we;
        mem_we_out_d = out_valid_d & main_d.mem_we;
        fwd_hit_d    = out_valid_d & main_d.rf_we & (main_d.a3 != '0);
    end

    // State, entries and output flops.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q      <= S_EMPTY;
            main_q       <= '0;
            skid_q       <= '0;
            out_valid_q  <= 1'b0;
            in_ready_q   <= 1'b1;
            rf_we_out_q  <= 1'b0;
            mem_we_out_q <= 1'b0;
            fwd_hit_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            main_q       <= main_d;
            skid_q       <= skid_d;
            out_valid_q  <= out_valid_d;
            in_ready_q   <= in_ready_d;
            rf_we_out_q  <= rf_we_out_d;
            mem_we_out_q <= mem_we_out_d;
            fwd_hit_q    <= fwd_hit_d;
        end
    end

    assign bus.in_ready_o  = in_ready_q;
    assign bus.out_valid_o = out_valid_q;
    assign bus.rd2_o       = main_q.rd2;
    assign bus.alu_o       = main_q.alu;
    assign bus.a3_o        = main_q.a3;
    assign bus.wb_sel_o    = main_q.wb_sel;
    assign bus.rf_we_o     = rf_we_out_q;
    assign bus.mem_we_o    = mem_we_out_q;
    assign bus.fwd_hit_o   = fwd_hit_q;

`ifdef PIPE_PERF_CNT_EN
    logic [CNT_W-1:0] stall_q;
    logic [CNT_W-1:0] bubble_q;

    // Saturating perf counters; flush does not touch them.
    always_ff @(posedge CLK) begin
        if (RST) begin
            stall_q  <= '0;
            bubble_q <= '0;
        end else begin
            if (out_valid_q && !bus.out_ready_i && !(&stall_q)) begin
                stall_q <= stall_q + CNT_W'(1);
            end
            if (!out_valid_q && !(&bubble_q)) begin
                bubble_q <= bubble_q + CNT_W'(1);
            end
        end
    end

    assign bus.stall_cnt_o  = stall_q;
    assign bus.bubble_cnt_o = bubble_q;
`else
    assign bus.stall_cnt_o  = CNT_W'(0);
    assign bus.bubble_cnt_o = CNT_W'(0);
`endif
endmodule
